// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one word-aligned bus transaction per memory op,
// stalls the pipeline until ack or timeout, and returns the extended load result.
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUres_in,
   input  logic [31:0] data2_in,
   input  logic [4:0]  MEM_ctrl_in,
   input  logic        WB_ctrl_in,
   output logic        stall_out,
   output logic [31:0] load_data,
   output logic        wb_en_out,
   output logic        mem_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT);

   logic [1:0] state;
   logic [7:0] wait_cnt;
   logic       timeout_flag;
   logic [2:0] size_q;
   logic [1:0] lane_q;

   logic       mem_read;
   logic       mem_write;
   logic [2:0] size;
   logic       is_mem;
   logic       both_set;
   logic       size_ok;
   logic       misaligned;
   logic       bad_op;
   logic       issue;
   logic       timeout_hit;

   function automatic logic [31:0] store_data(input logic [2:0] sz, input logic [31:0] d);
      case (sz)
         SZ_B, SZ_BU: return {4{d[7:0]}};
         SZ_H, SZ_HU: return {2{d[15:0]}};
         default:     return d;
      endcase
   endfunction

   function automatic logic [3:0] store_strb(input logic [2:0] sz, input logic [1:0] lane);
      case (sz)
         SZ_B, SZ_BU: return 4'b0001 << lane;
         SZ_H, SZ_HU: return lane[1] ? 4'b1100 : 4'b0011;
         default:     return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] sz, input logic [1:0] lane,
                                               input logic [31:0] rdata);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      case (lane)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = lane[1] ? rdata[31:16] : rdata[15:0];
      case (sz)
         SZ_B:    return 32'(b);
         SZ_BU:   return {24'd0, b};
         SZ_H:    return 32'(h);
         SZ_HU:   return {16'd0, h};
         default: return rdata;
      endcase
   endfunction

   assign mem_read  = MEM_ctrl_in[0];
   assign mem_write = MEM_ctrl_in[1];
   assign size      = MEM_ctrl_in[4:2];
   assign is_mem    = mem_read ^ mem_write;
   assign both_set  = mem_read & mem_write;
   assign size_ok   = (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
                      (size == SZ_BU) || (size == SZ_HU);
   assign misaligned = ((size == SZ_W) && (ALUres_in[1:0] != 2'b00)) ||
                       (((size == SZ_H) || (size == SZ_HU)) && ALUres_in[0]);
   assign bad_op     = both_set | (is_mem & (~size_ok | misaligned));
   assign issue      = is_mem & size_ok & ~misaligned;
   assign timeout_hit = ({1'b0, wait_cnt} + 9'd1) == TIMEOUT_LIMIT;

   // bus_req comes straight from the state so an async reset drops it at once
   assign bus_req = (state == WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wait_cnt     <= 8'd0;
         timeout_flag <= 1'b0;
         size_q       <= 3'd0;
         lane_q       <= 2'd0;
         bus_we       <= 1'b0;
         bus_addr     <= 32'd0;
         bus_wdata    <= 32'd0;
         bus_wstrb    <= 4'd0;
         load_data    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  bus_addr     <= {ALUres_in[31:2], 2'b00};
                  bus_we       <= mem_write;
                  bus_wdata    <= store_data(size, data2_in);
                  bus_wstrb    <= mem_write ? store_strb(size, ALUres_in[1:0]) : 4'd0;
                  size_q       <= size;
                  lane_q       <= ALUres_in[1:0];
                  wait_cnt     <= 8'd0;
                  timeout_flag <= 1'b0;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               if (bus_ack) begin
                  if (!bus_we) load_data <= load_extend(size_q, lane_q, bus_rdata);
                  state <= DONE;
               end else if (timeout_hit) begin
                  load_data    <= 32'd0;
                  timeout_flag <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               // Always return to IDLE: the instruction still on the inputs is the one just served
               timeout_flag <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      stall_out = 1'b0;
      wb_en_out = 1'b0;
      mem_err   = 1'b0;
      case (state)
         IDLE: begin
            if (bad_op)     mem_err   = 1'b1;
            else if (issue) stall_out = 1'b1;
            else            wb_en_out = WB_ctrl_in;
         end
         WAIT: stall_out = 1'b1;
         DONE: begin
            wb_en_out = WB_ctrl_in & ~timeout_flag;
            mem_err   = timeout_flag;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts every cycle's
// outputs, and literal checks pin the model on the key scenarios.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUres_in, data2_in, bus_rdata;
   logic [4:0]  MEM_ctrl_in;
   logic        WB_ctrl_in, bus_ack;
   logic        stall_out, wb_en_out, mem_err, bus_req, bus_we;
   logic [31:0] load_data, bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;

   int checks = 0;
   int failures = 0;

   logic        chk_en = 1'b0;
   logic        exp_stall, exp_req, exp_err, exp_wben, exp_we;
   logic [31:0] exp_addr, exp_wdata, m_ld;
   logic [3:0]  exp_wstrb;
   logic [7:0]  stall_hist = 8'd0, req_hist = 8'd0, wben_hist = 8'd0;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .ALUres_in(ALUres_in), .data2_in(data2_in),
      .MEM_ctrl_in(MEM_ctrl_in), .WB_ctrl_in(WB_ctrl_in), .stall_out(stall_out),
      .load_data(load_data), .wb_en_out(wb_en_out), .mem_err(mem_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   // Model helpers written directly from the lane rules with plain arithmetic.
   function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
      if (sz == 3'b000) return (d & 32'hFF) * 32'h01010101;
      if (sz == 3'b001) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [2:0] sz, input logic [31:0] a);
      if (sz == 3'b000) return 4'd1 << (a % 4);
      if (sz == 3'b001) return 4'd3 << (2 * ((a / 2) % 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_ext(input logic [2:0] sz, input logic [31:0] a,
                                         input logic [31:0] rd);
      logic [31:0] v;
      if (sz == 3'b010) return rd;
      if (sz == 3'b000 || sz == 3'b100) begin
         v = (rd >> (8 * (a % 4))) & 32'hFF;
         if (sz == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
      end else begin
         v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (sz == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
      end
      return v;
   endfunction

   task automatic set_exp(input logic s, input logic r, input logic e, input logic w);
      exp_stall = s; exp_req = r; exp_err = e; exp_wben = w;
   endtask

   always @(negedge clk) begin
      stall_hist <= {stall_hist[6:0], stall_out};
      req_hist   <= {req_hist[6:0], bus_req};
      wben_hist  <= {wben_hist[6:0], wb_en_out};
      if (chk_en) begin
         chk("stall_out", 32'(stall_out), 32'(exp_stall));
         chk("bus_req", 32'(bus_req), 32'(exp_req));
         chk("mem_err", 32'(mem_err), 32'(exp_err));
         chk("wb_en_out", 32'(wb_en_out), 32'(exp_wben));
         chk("load_data", load_data, m_ld);
         if (exp_req) begin
            chk("bus_addr", bus_addr, exp_addr);
            chk("bus_we", 32'(bus_we), 32'(exp_we));
            if (exp_we) begin
               chk("bus_wdata", bus_wdata, exp_wdata);
               chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
            end
         end
      end
   end

   // One instruction held on the inputs until served; ack_at = WAIT cycle of ack (0 = never).
   task automatic op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] d,
                     input logic wb, input int ack_at, input logic [31:0] rd,
                     input logic early_ack, input logic nosync);
      logic       r, w, mis, acked;
      logic [2:0] sz;
      r = ctrl[0]; w = ctrl[1]; sz = ctrl[4:2];
      if (!nosync) begin @(posedge clk); #1; end
      ALUres_in = a; data2_in = d; MEM_ctrl_in = ctrl; WB_ctrl_in = wb;
      bus_rdata = rd; bus_ack = early_ack;
      mis = (sz == 3'b010 && (a % 4) != 0) || ((sz == 3'b001 || sz == 3'b101) && (a % 2) != 0);
      if ((r && w) || ((r != w) && mis)) begin set_exp(0, 0, 1, 0); return; end
      if (r == w) begin set_exp(0, 0, 0, wb); return; end
      set_exp(1, 0, 0, 0);
      exp_addr = a & ~32'd3; exp_we = w;
      exp_wdata = m_wdata(sz, d); exp_wstrb = m_wstrb(sz, a);
      acked = 1'b0;
      for (int i = 1; i <= TO; i++) begin
         @(posedge clk); #1;
         bus_ack = (i == ack_at);
         set_exp(1, 1, 0, 0);
         if (i == ack_at) begin acked = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (!acked) m_ld = 32'd0;
      else if (r) m_ld = m_ext(sz, a, rd);
      set_exp(0, 0, !acked, wb && acked);
   endtask

   initial begin
      rst = 1'b1; ALUres_in = 0; data2_in = 0; MEM_ctrl_in = 5'd0; WB_ctrl_in = 1'b0;
      bus_rdata = 0; bus_ack = 1'b0; m_ld = 0;
      exp_addr = 0; exp_we = 0; exp_wdata = 0; exp_wstrb = 0;
      set_exp(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst bus_req", 32'(bus_req), 32'd0);
      chk("rst bus_we", 32'(bus_we), 32'd0);
      chk("rst bus_addr", bus_addr, 32'd0);
      chk("rst bus_wdata", bus_wdata, 32'd0);
      chk("rst bus_wstrb", 32'(bus_wstrb), 32'd0);
      chk("rst load_data", load_data, 32'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // non-memory op right after reset
      op(5'b00000, 32'h0, 32'h0, 1'b1, 0, 32'h0, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("nop stall", 32'(stall_out), 32'd0);
      chk("nop mem_err", 32'(mem_err), 32'd0);
      chk("nop wb_en", 32'(wb_en_out), 32'd1);

      // LW 0x100, ack in 2nd WAIT cycle
      op(5'b01001, 32'h100, 32'h0, 1'b1, 2, 32'hDEADBEEF, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("lw stall seq", 32'(stall_hist[3:0]), 32'b1110);
      chk("lw wb_en seq", 32'(wben_hist[3:0]), 32'b0001);
      chk("lw load_data", load_data, 32'hDEADBEEF);

      // LB / LBU 0x103; the LB also drives ack in IDLE, which must be ignored
      op(5'b00001, 32'h103, 32'h0, 1'b1, 1, 32'h80112233, 1'b1, 1'b0);
      @(negedge clk); #1;
      chk("lb load_data", load_data, 32'hFFFFFF80);
      op(5'b10001, 32'h103, 32'h0, 1'b1, 1, 32'h80112233, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("lbu load_data", load_data, 32'h00000080);

      // SH 0x202; bus fields stay registered after the access
      op(5'b00110, 32'h202, 32'h1234ABCD, 1'b0, 1, 32'h0, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("sh bus_addr", bus_addr, 32'h200);
      chk("sh bus_wdata", bus_wdata, 32'hABCDABCD);
      chk("sh bus_wstrb", 32'(bus_wstrb), 32'b1100);
      chk("sh bus_we", 32'(bus_we), 32'd1);
      chk("sh load kept", load_data, 32'h00000080);

      op(5'b00010, 32'h201, 32'h000000A5, 1'b0, 3, 32'h0, 1'b0, 1'b0);
      op(5'b00101, 32'h102, 32'h0, 1'b1, 1, 32'h80011234, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("lh load_data", load_data, 32'hFFFF8001);
      op(5'b10101, 32'h000, 32'h0, 1'b1, 1, 32'h1234F00D, 1'b0, 1'b0);
      op(5'b01010, 32'h010, 32'hCAFEF00D, 1'b0, 1, 32'h0, 1'b0, 1'b0);

      // misaligned and illegal ops
      op(5'b01001, 32'h101, 32'h0, 1'b1, 1, 32'h0, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("lw mis mem_err", 32'(mem_err), 32'd1);
      chk("lw mis bus_req", 32'(bus_req), 32'd0);
      chk("lw mis stall", 32'(stall_out), 32'd0);
      chk("lw mis wb_en", 32'(wb_en_out), 32'd0);
      op(5'b00101, 32'h103, 32'h0, 1'b1, 1, 32'h0, 1'b0, 1'b0);
      op(5'b01011, 32'h100, 32'h0, 1'b1, 1, 32'h0, 1'b0, 1'b0);

      // timeout: ack never arrives
      op(5'b01001, 32'h300, 32'h0, 1'b1, 0, 32'h55555555, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("to req seq", 32'(req_hist[5:0]), 32'b011110);
      chk("to mem_err", 32'(mem_err), 32'd1);
      chk("to load_data", load_data, 32'd0);
      chk("to wb_en", 32'(wb_en_out), 32'd0);

      // async reset in 3rd WAIT cycle, then the held op restarts
      @(posedge clk); #1;
      ALUres_in = 32'h100; MEM_ctrl_in = 5'b01001; WB_ctrl_in = 1'b1;
      bus_rdata = 32'h0BADF00D; bus_ack = 1'b0;
      set_exp(1, 0, 0, 0); exp_addr = 32'h100; exp_we = 1'b0;
      repeat (2) begin @(posedge clk); #1; set_exp(1, 1, 0, 0); end
      @(posedge clk); #1;
      #1; chk_en = 1'b0; rst = 1'b1; bus_ack = 1'b1;
      #1;
      chk("rst wait bus_req", 32'(bus_req), 32'd0);
      chk("rst wait bus_addr", bus_addr, 32'd0);
      chk("rst wait stall", 32'(stall_out), 32'd1);
      @(posedge clk); #1;
      chk("rst wait load_data", load_data, 32'd0);
      rst = 1'b0; bus_ack = 1'b0; m_ld = 32'd0; chk_en = 1'b1;
      op(5'b01001, 32'h100, 32'h0, 1'b1, 1, 32'h0BADF00D, 1'b0, 1'b1);
      @(negedge clk); #1;
      chk("restart load_data", load_data, 32'h0BADF00D);

      op(5'b00000, 32'h0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
